// File: rtl/fetch_sequencer.sv
// Fetch program counter and EX-load sequencing for the 3-stage core.
// Chooses each cycle between loading imem[pc_fetch] into EX or inserting a bubble.
module fetch_sequencer #(
  parameter int              PC_W         = 12,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_ex,
  input  logic [PC_W-1:0] target_ex,
  input  logic            halt_ex,
  input  logic            stall_req,
  input  logic            step_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc_fetch,
  output logic [PC_W-1:0] pc_ex,
  output logic            fetch_en,
  output logic            bubble_ex,
  output logic            ex_valid,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t          state_r, state_s;
  logic [2:0]      flush_cnt_r, flush_cnt_s;
  logic [PC_W-1:0] pc_fetch_r, pc_fetch_s;
  logic [PC_W-1:0] pc_ex_r, pc_ex_s;
  logic            ex_valid_r, ex_valid_s;
  logic            halted_r, halted_s;
  logic            fetch_en_s, bubble_s;
  logic            redirect_v_s, halt_v_s;
  logic [PC_W-1:0] pc_fetch_inc_s;

  // A bubble in EX cannot branch or halt.
  assign redirect_v_s   = redirect_ex & ex_valid_r;
  assign halt_v_s       = halt_ex & ex_valid_r;
  assign pc_fetch_inc_s = pc_fetch_r + PC_W'(1);

  // Next-state, next-PC and the combinational EX load selects.
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    pc_fetch_s  = pc_fetch_r;
    pc_ex_s     = pc_ex_r;
    ex_valid_s  = 1'b0;
    fetch_en_s  = 1'b0;
    bubble_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (halt_v_s) begin
          bubble_s = 1'b1;
          state_s  = ST_HALT;
        end else if (redirect_v_s) begin
          bubble_s   = 1'b1;
          pc_fetch_s = target_ex;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_s = FLUSH_LOAD;
            state_s     = ST_FLUSH;
          end else begin
            state_s = ST_RUN;
          end
        end else if (stall_req) begin
          bubble_s = 1'b1;
        end else begin
          fetch_en_s = 1'b1;
          pc_ex_s    = pc_fetch_r;
          pc_fetch_s = pc_fetch_inc_s;
          ex_valid_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        bubble_s = 1'b1;
        // Leave on the bubble that takes the counter to zero.
        if (flush_cnt_r > 3'd1) begin
          flush_cnt_s = flush_cnt_r - 3'd1;
          state_s     = ST_FLUSH;
        end else begin
          flush_cnt_s = 3'd0;
          state_s     = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume) begin
          bubble_s = 1'b1;
          state_s  = ST_RUN;
        end else if (step_req) begin
          fetch_en_s = 1'b1;
          pc_ex_s    = pc_fetch_r;
          pc_fetch_s = pc_fetch_inc_s;
          ex_valid_s = 1'b1;
          state_s    = ST_STEP;
        end else begin
          bubble_s = 1'b1;
        end
      end
      ST_STEP: begin
        bubble_s = 1'b1;
        state_s  = ST_HALT;
        if (redirect_v_s) begin
          pc_fetch_s = target_ex;
        end else begin
          pc_fetch_s = pc_fetch_r;
        end
      end
      default: begin
        bubble_s    = 1'b1;
        flush_cnt_s = 3'd0;
        state_s     = ST_RUN;
      end
    endcase
    halted_s = (state_s == ST_HALT) || (state_s == ST_STEP);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 3'd0;
      pc_fetch_r  <= RESET_PC;
      pc_ex_r     <= '0;
      ex_valid_r  <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= flush_cnt_s;
      pc_fetch_r  <= pc_fetch_s;
      pc_ex_r     <= pc_ex_s;
      ex_valid_r  <= ex_valid_s;
      halted_r    <= halted_s;
    end
  end

  assign pc_fetch  = pc_fetch_r;
  assign pc_ex     = pc_ex_r;
  assign ex_valid  = ex_valid_r;
  assign halted    = halted_r;
  assign fetch_en  = fetch_en_s;
  assign bubble_ex = bubble_s;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: FLUSH_CYCLES=1 and =3 instances share stimulus and
// are each compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_ex, halt_ex, stall_req, step_req, resume;
  logic [11:0] target_ex;
  logic [11:0] pcf_o [2];
  logic [11:0] pce_o [2];
  logic        fe_o  [2];
  logic        bb_o  [2];
  logic        exv_o [2];
  logic        hlt_o [2];

  typedef struct {
    int pcf;
    int pce;
    bit exv;
    bit halted;
    bit step;
    int flush_left;
  } mdl_t;

  mdl_t m [2];
  int   checks = 0;
  int   errors = 0;

  fetch_sequencer #(.PC_W(12), .RESET_PC(12'h000), .FLUSH_CYCLES(1)) dut_f1 (
    .clk(clk), .rst(rst), .redirect_ex(redirect_ex), .target_ex(target_ex),
    .halt_ex(halt_ex), .stall_req(stall_req), .step_req(step_req), .resume(resume),
    .pc_fetch(pcf_o[0]), .pc_ex(pce_o[0]), .fetch_en(fe_o[0]), .bubble_ex(bb_o[0]),
    .ex_valid(exv_o[0]), .halted(hlt_o[0])
  );

  fetch_sequencer #(.PC_W(12), .RESET_PC(12'h000), .FLUSH_CYCLES(3)) dut_f3 (
    .clk(clk), .rst(rst), .redirect_ex(redirect_ex), .target_ex(target_ex),
    .halt_ex(halt_ex), .stall_req(stall_req), .step_req(step_req), .resume(resume),
    .pc_fetch(pcf_o[1]), .pc_ex(pce_o[1]), .fetch_en(fe_o[1]), .bubble_ex(bb_o[1]),
    .ex_valid(exv_o[1]), .halted(hlt_o[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic int flush_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // One cycle of the fetch rules: what EX gets now and where the PCs go next.
  function automatic void model_eval(input int i, input mdl_t cur, output bit fe, output bit bb,
                                     output mdl_t nx);
    bit rd;
    bit hd;
    rd = redirect_ex && cur.exv;
    hd = halt_ex && cur.exv;
    nx = cur;
    nx.exv = 1'b0;
    fe = 1'b0;
    bb = 1'b0;
    if (cur.step) begin
      bb = 1'b1;
      nx.step = 1'b0;
      if (rd) nx.pcf = int'(target_ex);
    end else if (cur.halted) begin
      if (resume) begin
        bb = 1'b1;
        nx.halted = 1'b0;
      end else if (step_req) begin
        fe = 1'b1;
        nx.pce = cur.pcf;
        nx.pcf = (cur.pcf + 1) % 4096;
        nx.exv = 1'b1;
        nx.step = 1'b1;
      end else begin
        bb = 1'b1;
      end
    end else if (cur.flush_left > 0) begin
      bb = 1'b1;
      nx.flush_left = cur.flush_left - 1;
    end else if (hd) begin
      bb = 1'b1;
      nx.halted = 1'b1;
    end else if (rd) begin
      bb = 1'b1;
      nx.pcf = int'(target_ex);
      nx.flush_left = flush_of(i) - 1;
    end else if (stall_req) begin
      bb = 1'b1;
    end else begin
      fe = 1'b1;
      nx.pce = cur.pcf;
      nx.pcf = (cur.pcf + 1) % 4096;
      nx.exv = 1'b1;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) m[i] = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "/pc_fetch"}, i, pcf_o[i], m[i].pcf);
      chk({tag, "/pc_ex"},    i, pce_o[i], m[i].pce);
      chk({tag, "/ex_valid"}, i, exv_o[i], m[i].exv);
      chk({tag, "/halted"},   i, hlt_o[i], m[i].halted);
    end
  endtask

  // Check the EX load selects for the current inputs, clock once, check state.
  task automatic do_cycle(input string tag);
    bit   fe, bb;
    mdl_t nx [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      model_eval(i, m[i], fe, bb, nx[i]);
      chk({tag, "/fetch_en"},  i, fe_o[i], fe);
      chk({tag, "/bubble_ex"}, i, bb_o[i], bb);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = nx[i];
    #1;
    check_regs(tag);
  endtask

  task automatic clear_in();
    redirect_ex = 1'b0; halt_ex = 1'b0; stall_req = 1'b0;
    step_req = 1'b0; resume = 1'b0; target_ex = 12'h000;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_regs("reset");
    rst = 1'b0;

    repeat (4) do_cycle("run");
    chk("pc_ex_before_redirect", 0, pce_o[0], 32'd3);

    redirect_ex = 1'b1; target_ex = 12'h100;
    do_cycle("redirect");
    clear_in();
    chk("redirect_target", 0, pcf_o[0], 32'h100);
    repeat (5) do_cycle("flush");

    stall_req = 1'b1;
    repeat (2) do_cycle("stall");
    clear_in();
    repeat (2) do_cycle("unstall");

    halt_ex = 1'b1; redirect_ex = 1'b1; target_ex = 12'h0AB;
    do_cycle("halt_vs_redirect");
    clear_in();
    chk("halt_one_cycle", 0, hlt_o[0], 32'd1);
    repeat (2) do_cycle("halted");

    step_req = 1'b1;
    do_cycle("step1");
    clear_in();
    redirect_ex = 1'b1; target_ex = 12'hFFF;
    do_cycle("step1_redirect");
    clear_in();
    do_cycle("halted2");
    step_req = 1'b1;
    do_cycle("step2");
    clear_in();
    do_cycle("step2_exec");
    step_req = 1'b1; resume = 1'b1;
    do_cycle("resume_over_step");
    clear_in();
    repeat (4) do_cycle("wrap");

    repeat (400) begin
      redirect_ex = ($urandom_range(0, 7) == 0);
      halt_ex     = ($urandom_range(0, 15) == 0);
      stall_req   = ($urandom_range(0, 5) == 0);
      step_req    = ($urandom_range(0, 3) == 0);
      resume      = ($urandom_range(0, 7) == 0);
      target_ex   = 12'($urandom);
      do_cycle("rand");
    end
    clear_in();

    resume = 1'b1;
    do_cycle("resync");
    clear_in();
    repeat (4) do_cycle("resync_run");
    redirect_ex = 1'b1; target_ex = 12'($urandom);
    do_cycle("enter_flush");
    clear_in();
    #1 rst = 1'b1;
    #1 model_reset();
    check_regs("async_rst_flush");
    #1 rst = 1'b0;
    repeat (3) do_cycle("after_rst1");

    halt_ex = 1'b1;
    do_cycle("halt_again");
    clear_in();
    step_req = 1'b1;
    do_cycle("enter_step");
    clear_in();
    #1 rst = 1'b1;
    #1 model_reset();
    check_regs("async_rst_step");
    #1 rst = 1'b0;
    repeat (3) do_cycle("after_rst2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
